// File: rtl/load_store_unit.sv
// Byte-wide memory load/store sequencer for 1- or 2-byte CPU accesses.
// Word accesses are enabled by defining LSU_WORD_EN; otherwise every access is a byte access.
module load_store_unit #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic                    req_word,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic                    resp_valid,
  output logic [2*DATA_WIDTH-1:0] resp_rdata,
  output logic                    mem_write_en,
  output logic                    mem_read_en,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_data_in,
  input  logic [DATA_WIDTH-1:0]   mem_data_out
);

  typedef enum logic [2:0] {IDLE, ACC_LO, ACC_HI, CAP, DONE} state_t;

  state_t                  state_q, state_d;
  logic                    write_q, write_d;
  logic                    word_q, word_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [2*DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_lo_q, rdata_lo_d;
  logic                    resp_valid_q, resp_valid_d;
  logic [2*DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic                    mem_we_q, mem_we_d;
  logic                    mem_re_q, mem_re_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_din_q, mem_din_d;

`ifndef LSU_WORD_EN
  logic unused_req_word;
  assign unused_req_word = req_word;
`endif

  // Memory controls are registered: they are computed on the edge that enters
  // the access state, so they are stable for the whole ACC_LO/ACC_HI cycle.
  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    word_d       = word_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_lo_d   = rdata_lo_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    mem_we_d     = 1'b0;
    mem_re_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_din_d    = mem_din_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
`ifdef LSU_WORD_EN
          word_d  = req_word;
`else
          word_d  = 1'b0;
`endif
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          mem_addr_d = req_addr;
          mem_we_d   = req_write;
          mem_re_d   = ~req_write;
          if (req_write) mem_din_d = req_wdata[DATA_WIDTH-1:0];
          state_d = ACC_LO;
        end
      end
      ACC_LO: begin
        if (word_q) begin
          mem_addr_d = addr_q + 1'b1;
          mem_we_d   = write_q;
          mem_re_d   = ~write_q;
          if (write_q) mem_din_d = wdata_q[2*DATA_WIDTH-1:DATA_WIDTH];
          state_d = ACC_HI;
        end else if (!write_q) begin
          state_d = CAP;
        end else begin
          resp_valid_d = 1'b1;
          state_d      = DONE;
        end
      end
      ACC_HI: begin
        if (!write_q) begin
          rdata_lo_d = mem_data_out;
          state_d    = CAP;
        end else begin
          resp_valid_d = 1'b1;
          state_d      = DONE;
        end
      end
      CAP: begin
        if (word_q) resp_rdata_d = {mem_data_out, rdata_lo_q};
        else        resp_rdata_d = {{DATA_WIDTH{1'b0}}, mem_data_out};
        resp_valid_d = 1'b1;
        state_d      = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      word_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_lo_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      word_q       <= word_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_lo_q   <= rdata_lo_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      mem_we_q     <= mem_we_d;
      mem_re_q     <= mem_re_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign resp_valid   = resp_valid_q;
  assign resp_rdata   = resp_rdata_q;
  assign mem_write_en = mem_we_q;
  assign mem_read_en  = mem_re_q;
  assign mem_addr     = mem_addr_q;
  assign mem_data_in  = mem_din_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural synchronous byte memory.
module tb_load_store_unit;
  localparam int AW = 16;
  localparam int DW = 8;
`ifdef LSU_WORD_EN
  localparam bit WORD_EN = 1'b1;
`else
  localparam bit WORD_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_write, req_word;
  logic [AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic          resp_valid;
  logic [2*DW-1:0] resp_rdata;
  logic          mem_write_en, mem_read_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_in, mem_data_out;

  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;
  logic [DW-1:0] mem [0:65535];

  typedef struct { logic is_load; logic [15:0] data; int lat; } exp_t;
  typedef struct { logic [15:0] data; int lat; } obs_t;
  exp_t exp_q[$];
  obs_t obs_q[$];
  int   acc_q[$];
  obs_t mon_o;
  int   cyc = 0;
  int   resp_cnt = 0;
  int   both_en_cnt = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_word(req_word), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_write_en) mem[mem_addr] <= mem_data_in;
    if (mem_read_en) mem_data_out <= mem[mem_addr];
  end

  // Cycle index 0 is the cycle in which the request is accepted.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      acc_q.delete();
    end else begin
      if (mem_read_en && mem_write_en) both_en_cnt = both_en_cnt + 1;
      if (resp_valid) begin
        mon_o.data = resp_rdata;
        mon_o.lat  = (acc_q.size() > 0) ? cyc - acc_q.pop_front() : 999;
        obs_q.push_back(mon_o);
        resp_cnt = resp_cnt + 1;
      end
      if (req_valid && req_ready) acc_q.push_back(cyc);
    end
  end

  function automatic int lat_of(input logic wr, input logic wd);
    logic w;
    w = wd & WORD_EN;
    if (wr) return w ? 3 : 2;
    return w ? 4 : 3;
  endfunction

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_addr = a; pre_data = d; pre_we = 1'b1;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic issue(input logic wr, input logic wd, input logic [AW-1:0] a,
                       input logic [15:0] wdat, input logic [15:0] exp_data);
    exp_t e;
    int n;
    e.is_load = ~wr; e.data = exp_data; e.lat = lat_of(wr, wd);
    exp_q.push_back(e);
    n = 0;
    @(posedge clk); #1;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL ready_wait: req_ready=%b required 1", req_ready);
    end
    req_valid = 1'b1; req_write = wr; req_word = wd; req_addr = a; req_wdata = wdat;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input string name);
    exp_t e;
    obs_t o;
    int n;
    e = exp_q.pop_front();
    n = 0;
    while (obs_q.size() == 0 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (obs_q.size() == 0) begin
      errors++; $display("FAIL %s_timeout: no resp_valid within 50 cycles", name);
    end else begin
      o = obs_q.pop_front();
      checks++;
      if (o.lat !== e.lat) begin
        errors++; $display("FAIL %s_latency: got %0d required %0d", name, o.lat, e.lat);
      end
      if (e.is_load) begin
        checks++;
        if (o.data !== e.data) begin
          errors++; $display("FAIL %s_rdata: got %h required %h", name, o.data, e.data);
        end
      end
    end
  endtask

  task automatic check_mem(input string name, input logic [AW-1:0] a, input logic [DW-1:0] d);
    checks++;
    if (mem[a] !== d) begin
      errors++; $display("FAIL %s: mem[%h]=%h required %h", name, a, mem[a], d);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (resp_valid !== 1'b0 || resp_rdata !== 16'h0 || mem_read_en !== 1'b0 ||
        mem_write_en !== 1'b0 || mem_addr !== 16'h0 || mem_data_in !== 8'h0) begin
      errors++;
      $display("FAIL %s: rv=%b rd=%h re=%b we=%b addr=%h din=%h required all zero",
               name, resp_valid, resp_rdata, mem_read_en, mem_write_en, mem_addr, mem_data_in);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_outputs");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: req_ready=%b required 1", req_ready);
    end
  endtask

  task automatic test_byte();
    issue(1'b1, 1'b0, 16'h0010, 16'h00AB, 16'h0);
    wait_resp("byte_store");
    check_mem("byte_store_mem", 16'h0010, 8'hAB);
    issue(1'b0, 1'b0, 16'h0010, 16'h0, 16'h00AB);
    wait_resp("byte_load");
    issue(1'b1, 1'b0, 16'h0020, 16'hCC77, 16'h0);
    wait_resp("store_after_load");
    check_mem("byte_store2_mem", 16'h0020, 8'h77);
    check_mem("byte_store2_hi_untouched", 16'h0021, 8'h42);
    checks++;
    if (resp_rdata !== 16'h00AB) begin
      errors++; $display("FAIL store_keeps_rdata: got %h required 00ab", resp_rdata);
    end
  endtask

  task automatic test_word();
    issue(1'b1, 1'b1, 16'h0100, 16'h1234, 16'h0);
    wait_resp("word_store");
    check_mem("word_store_lo", 16'h0100, 8'h34);
    check_mem("word_store_hi", 16'h0101, WORD_EN ? 8'h12 : 8'h99);
    issue(1'b0, 1'b1, 16'h0100, 16'h0, WORD_EN ? 16'h1234 : 16'h0034);
    wait_resp("word_load");
    issue(1'b0, 1'b0, 16'h0101, 16'h0, WORD_EN ? 16'h0012 : 16'h0099);
    wait_resp("byte_load_hi");
  endtask

  task automatic test_wrap();
    issue(1'b1, 1'b1, 16'hFFFF, 16'hBEEF, 16'h0);
    wait_resp("wrap_store");
    check_mem("wrap_lo", 16'hFFFF, 8'hEF);
    check_mem("wrap_hi", 16'h0000, WORD_EN ? 8'hBE : 8'h5A);
    issue(1'b0, 1'b1, 16'hFFFF, 16'h0, WORD_EN ? 16'hBEEF : 16'h00EF);
    wait_resp("wrap_load");
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] addrs [3];
    logic [15:0]   datas [3];
    exp_t e;
    int r0, n, busy;
    addrs[0] = 16'h0200; addrs[1] = 16'h0202; addrs[2] = 16'h0204;
    datas[0] = WORD_EN ? 16'h2211 : 16'h0011;
    datas[1] = WORD_EN ? 16'h4433 : 16'h0033;
    datas[2] = WORD_EN ? 16'h6655 : 16'h0055;
    r0 = resp_cnt;
    for (int i = 0; i < 3; i++) begin
      e.is_load = 1'b1; e.data = datas[i]; e.lat = lat_of(1'b0, 1'b1);
      exp_q.push_back(e);
      req_valid = 1'b1; req_write = 1'b0; req_word = 1'b1; req_addr = addrs[i]; req_wdata = 16'hFFFF;
      n = 0;
      while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      if (i == 2) req_valid = 1'b0;
      busy = 0;
      while (!req_ready && busy < 50) begin @(posedge clk); #1; busy++; end
      checks++;
      if (busy !== lat_of(1'b0, 1'b1)) begin
        errors++; $display("FAIL b2b_busy_%0d: not-ready cycles %0d required %0d",
                           i, busy, lat_of(1'b0, 1'b1));
      end
    end
    for (int i = 0; i < 3; i++) wait_resp("b2b_load");
    checks++;
    if (resp_cnt - r0 !== 3) begin
      errors++; $display("FAIL b2b_pulses: got %0d required 3", resp_cnt - r0);
    end
  endtask

  task automatic test_reset_mid();
    int r0;
    r0 = resp_cnt;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b1; req_word = 1'b1; req_addr = 16'h0300; req_wdata = 16'h5566;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("reset_mid_outputs");
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_mid_held");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (resp_cnt !== r0 || obs_q.size() != 0) begin
      errors++; $display("FAIL reset_mid_resp: pulses %0d required 0", resp_cnt - r0);
    end
    check_mem("reset_mid_lo", 16'h0300, 8'h66);
    check_mem("reset_mid_hi", 16'h0301, 8'h77);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid_ready: req_ready=%b required 1", req_ready);
    end
  endtask

  task automatic test_enables();
    checks++;
    if (both_en_cnt !== 0) begin
      errors++; $display("FAIL both_enables: %0d cycles required 0", both_en_cnt);
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL stray_resp: %0d unexpected responses required 0", obs_q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_word = 1'b0; req_addr = '0; req_wdata = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    test_reset();
    preload(16'h0021, 8'h42);
    preload(16'h0101, 8'h99);
    preload(16'h0000, 8'h5A);
    preload(16'h0200, 8'h11); preload(16'h0201, 8'h22);
    preload(16'h0202, 8'h33); preload(16'h0203, 8'h44);
    preload(16'h0204, 8'h55); preload(16'h0205, 8'h66);
    preload(16'h0300, 8'h00); preload(16'h0301, 8'h77);
    test_byte();
    test_word();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_enables();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL provide parameter ADDR_WIDTH, default 16, byte address width.
REQ-002 SHALL provide parameter DATA_WIDTH, default 8, memory byte width; word width is 2*DATA_WIDTH.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  1  CPU request present.
REQ-007 req_ready  output  1  unit idle and able to accept a request.
REQ-008 req_write  input  1  1 = store, 0 = load.
REQ-009 req_word  input  1  1 = 2-byte access, 0 = 1-byte access.
REQ-010 req_addr  input  ADDR_WIDTH  byte address of the access.
REQ-011 req_wdata  input  2*DATA_WIDTH  store data; low byte at req_addr.
REQ-012 resp_valid  output  1  one-cycle completion pulse for loads and stores.
REQ-013 resp_rdata  output  2*DATA_WIDTH  load result, held until the next load completes.
REQ-014 mem_write_en  output  1  to data memory write enable.
REQ-015 mem_read_en  output  1  to data memory read enable.
REQ-016 mem_addr  output  ADDR_WIDTH  to data memory address.
REQ-017 mem_data_in  output  DATA_WIDTH  to data memory write byte.
REQ-018 mem_data_out  input  DATA_WIDTH  from data memory; valid one cycle after mem_read_en.

Function
REQ-019 The unit SHALL use states IDLE, ACC_LO, ACC_HI, CAP and DONE.
REQ-020 req_ready SHALL be 1 only in IDLE; a request is accepted on an edge where req_valid and req_ready are both 1.
REQ-021 On acceptance, the unit SHALL latch req_write, req_word, req_addr and req_wdata and go to ACC_LO; request inputs are ignored at all other times.
REQ-022 ACC_LO SHALL drive mem_addr = latched addr and assert exactly one of mem_read_en or mem_write_en; a store drives mem_data_in = wdata low byte.
REQ-023 From ACC_LO, the next state SHALL be ACC_HI if word, else CAP if load, else DONE.
REQ-024 ACC_HI SHALL drive mem_addr = addr+1, modulo 2^ADDR_WIDTH (0xFFFF wraps to 0x0000), and the wdata high byte for a store; on a load it captures mem_data_out into rdata low byte.
REQ-025 From ACC_HI, the next state SHALL be CAP for a load and DONE for a store.
REQ-026 CAP SHALL capture mem_data_out into the rdata high byte for a word load, or into the low byte with the high byte zeroed for a byte load, and then go to DONE.
REQ-027 DONE SHALL assert resp_valid for exactly one cycle and then return to IDLE.
REQ-028 resp_rdata SHALL update only on loads; stores leave it unchanged.
REQ-029 mem_read_en and mem_write_en SHALL never be 1 in the same cycle, and SHALL both be 0 in IDLE, CAP and DONE.
REQ-030 Latency from acceptance edge to resp_valid cycle SHALL be: byte store 2, byte load 3, word store 3, word load 4; peak throughput is one request per latency+1 cycles.
REQ-031 mem_addr and mem_data_in SHALL hold their last values outside access states.

Reset
REQ-032 While rst=1 the unit SHALL be in IDLE with resp_valid=0, resp_rdata=0, mem_read_en=0, mem_write_en=0, mem_addr=0 and mem_data_in=0, and req_ready SHALL be 1 once rst=0.
REQ-033 Reset during any non-IDLE state SHALL abandon the access with no resp_valid; a word store reset after ACC_LO leaves only the low byte written.

Configuration
REQ-034 The macro LSU_WORD_EN SHALL control word accesses.
REQ-035 With LSU_WORD_EN defined, req_word is honoured as above.
REQ-036 Without LSU_WORD_EN, req_word SHALL be ignored, ACC_HI SHALL be unreachable, all accesses are byte accesses, and word stores write only the low byte.

Verification
REQ-037 Byte store 0xAB to 0x0010, then byte load 0x0010 -> resp_rdata=0x00AB; responses arrive 2 and 3 cycles after acceptance.
REQ-038 Word store 0x1234 to 0x0100, then word load -> mem holds 0x34@0x0100 and 0x12@0x0101; resp_rdata=0x1234 at latency 4.
REQ-039 Word store 0xBEEF to 0xFFFF -> 0xEF@0xFFFF and 0xBE@0x0000 (address wrap).
REQ-040 req_valid held high for 3 back-to-back loads -> exactly 3 resp_valid pulses, req_ready low during each access, never both mem enables high.
REQ-041 rst asserted in ACC_HI of a word store 0x5566 -> no resp_valid, 0x66 written, high byte untouched, outputs at reset values.
REQ-042 Built without LSU_WORD_EN: word load at 0x0100 -> resp_rdata=0x0034, latency 3.
